logs_orbit_column: RTL and testbench

Downstream stage of the logistic-map iterator. For one value of `r`, it restarts the iterator, discards a fixed number of settling iterations, then records the next SAMPLES values of `x` into a one-hot occupancy bitmap with one bit per `x` code. It hands that bitmap to the display side as a single column of the bifurcation diagram, using a valid/ack handshake.

---
 rtl/logs_orbit_column.sv | 111 +++++++++++
 tb/tb_logs_orbit_column.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logs_orbit_column.sv
// Bifurcation column builder: restarts the logistic-map iterator, skips SETTLE
// iterations, then ORs the next SAMPLES x codes into a one-hot occupancy bitmap.
module logs_orbit_column #(
  parameter int FRAC    = 4,
  parameter int SETTLE  = 16,
  parameter int SAMPLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [FRAC-1:0]      x,
  input  logic                 next_ready,
  output logic                 iter_reset,
  output logic                 busy,
  output logic                 col_valid,
  output logic [2**FRAC-1:0]   col_bits,
  input  logic                 col_ack
);

  // state   | meaning
  // IDLE    | waiting for start, last column (if any) still on col_bits
  // RESTART | one cycle; arms the iter_reset pulse
  // SETTLE  | discarding transient iterations
  // COLLECT | recording x codes into col_bits
  // HOLD    | column complete, col_valid high until col_ack

  localparam int MAXC = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
  localparam logic [CW-1:0] SAMPLES_C = CW'(SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_SETTLE,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);

  // iter_reset and busy are registered off the RESTART state, so they rise one
  // edge after the state does; the pulse overlaps the first SETTLE/COLLECT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      iter_reset <= 1'b0;
      busy       <= 1'b0;
      col_valid  <= 1'b0;
      col_bits   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RESTART;
            col_bits <= '0;
            cnt      <= '0;
          end
        end
        S_RESTART: begin
          iter_reset <= 1'b1;
          busy       <= 1'b1;
          state      <= (SETTLE == 0) ? S_COLLECT : S_SETTLE;
        end
        S_SETTLE: begin
          iter_reset <= 1'b0;
          if (next_ready) begin
            if (cnt_inc == SETTLE_C) begin
              state <= S_COLLECT;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_COLLECT: begin
          iter_reset <= 1'b0;
          if (next_ready) begin
            col_bits[x] <= 1'b1;
            cnt         <= cnt_inc;
            if (cnt_inc == SAMPLES_C) begin
              state     <= S_HOLD;
              col_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (col_ack && start) begin
            state     <= S_RESTART;
            col_valid <= 1'b0;
            col_bits  <= '0;
            cnt       <= '0;
          end else if (col_ack) begin
            state     <= S_IDLE;
            col_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logs_orbit_column.sv
// Directed bench: three instances (SETTLE/SAMPLES = 2/4, 0/1, defaults) driven
// on the falling edge and checked on the falling edge against hand values.
module tb_logs_orbit_column;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // instance a: SETTLE=2, SAMPLES=4
  logic        start_a = 0, nr_a = 0, ack_a = 0;
  logic [3:0]  x_a = 0;
  logic        ir_a, busy_a, cv_a;
  logic [15:0] bits_a;

  logs_orbit_column #(.FRAC(4), .SETTLE(2), .SAMPLES(4)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .x(x_a), .next_ready(nr_a),
    .iter_reset(ir_a), .busy(busy_a), .col_valid(cv_a), .col_bits(bits_a),
    .col_ack(ack_a));

  // instance b: SETTLE=0, SAMPLES=1
  logic        start_b = 0, nr_b = 0, ack_b = 0;
  logic [3:0]  x_b = 0;
  logic        ir_b, busy_b, cv_b;
  logic [15:0] bits_b;

  logs_orbit_column #(.FRAC(4), .SETTLE(0), .SAMPLES(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .x(x_b), .next_ready(nr_b),
    .iter_reset(ir_b), .busy(busy_b), .col_valid(cv_b), .col_bits(bits_b),
    .col_ack(ack_b));

  // instance c: defaults, fed by a stub iterator with period 11
  logic        start_c = 0, nr_c = 0, ack_c = 0;
  logic [3:0]  x_c = 0;
  logic        ir_c, busy_c, cv_c;
  logic [15:0] bits_c;

  logs_orbit_column u_c (
    .clk(clk), .reset(reset), .start(start_c), .x(x_c), .next_ready(nr_c),
    .iter_reset(ir_c), .busy(busy_c), .col_valid(cv_c), .col_bits(bits_c),
    .col_ack(ack_c));

  // first pulse 11 cycles after iter_reset falls; x cycles through all 16 codes
  int stub_cnt = 0;
  int stub_idx = 0;
  bit stub_run = 0;
  always @(negedge clk) begin
    nr_c <= 1'b0;
    if (ir_c) begin
      stub_run <= 1'b1;
      stub_cnt <= 0;
    end else if (stub_run) begin
      if (stub_cnt + 1 == 11) begin
        nr_c     <= 1'b1;
        x_c      <= 4'(stub_idx);
        stub_idx <= stub_idx + 1;
        stub_cnt <= 0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  bit mon_en = 0, saw_restart = 0;
  always @(negedge clk) if (mon_en && ir_a) saw_restart <= 1'b1;

  task automatic pulse_a(input logic [3:0] v);
    repeat (10) @(negedge clk);
    nr_a = 1'b1;
    x_a  = v;
    @(negedge clk);
    nr_a = 1'b0;
  endtask

  initial begin
    // reset held 3 cycles with start high
    reset = 1'b1;
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ir", ir_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_cv", cv_a, 0);
    check("rst_bits", bits_a, 0);
    check("rst_bits_b", bits_b, 0);

    // start honoured once reset drops
    reset = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    check("start_e0_ir", ir_a, 0);
    @(negedge clk);
    check("start_e1_ir", ir_a, 1);
    check("start_e1_busy", busy_a, 1);
    @(negedge clk);
    check("start_e2_ir", ir_a, 0);
    check("start_e2_busy", busy_a, 1);

    pulse_a(4'd1);
    pulse_a(4'd2);
    check("settle_discard", bits_a, 16'h0000);
    pulse_a(4'd3);
    check("first_sample", bits_a, 16'h0008);
    pulse_a(4'd12);
    pulse_a(4'd3);
    check("cv_before_last", cv_a, 0);
    pulse_a(4'd12);
    check("cv_last", cv_a, 1);
    check("bits_last", bits_a, 16'h1008);

    // HOLD without ack: start and next_ready ignored
    mon_en  = 1'b1;
    start_a = 1'b1;
    for (int i = 0; i < 9; i++) pulse_a(4'd5);
    start_a = 1'b0;
    mon_en  = 1'b0;
    check("hold_bits", bits_a, 16'h1008);
    check("hold_cv", cv_a, 1);
    check("hold_no_restart", saw_restart, 0);
    check("hold_busy", busy_a, 1);
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check("ack_cv", cv_a, 0);
    check("ack_busy", busy_a, 0);
    check("ack_bits_kept", bits_a, 16'h1008);

    // second column, then back-to-back ack+start
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check("col2_ir", ir_a, 1);
    pulse_a(4'd0);
    pulse_a(4'd15);
    pulse_a(4'd0);
    pulse_a(4'd15);
    pulse_a(4'd6);
    pulse_a(4'd6);
    check("col2_cv", cv_a, 1);
    check("col2_bits", bits_a, 16'h8041);

    ack_a   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    ack_a   = 1'b0;
    start_a = 1'b0;
    check("b2b_cv", cv_a, 0);
    check("b2b_bits", bits_a, 16'h0000);
    check("b2b_busy", busy_a, 1);
    // stale pulse during the RESTART cycle must not count
    nr_a = 1'b1;
    x_a  = 4'd9;
    @(negedge clk);
    nr_a = 1'b0;
    check("b2b_ir", ir_a, 1);
    check("b2b_busy2", busy_a, 1);
    pulse_a(4'd1);
    pulse_a(4'd2);
    pulse_a(4'd4);
    check("b2b_stale_ignored", bits_a, 16'h0010);
    check("b2b_collecting", cv_a, 0);

    // reset mid-COLLECT
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_bits", bits_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_ir", ir_a, 0);
    check("midrst_cv", cv_a, 0);
    pulse_a(4'd3);
    check("idle_nr_ignored", bits_a, 0);

    // instance b: SETTLE=0, SAMPLES=1
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nr_b = 1'b1;
    x_b  = 4'd9;
    @(negedge clk);
    nr_b = 1'b0;
    check("b_ir", ir_b, 1);
    check("b_bits_clear", bits_b, 0);
    repeat (10) @(negedge clk);
    nr_b = 1'b1;
    x_b  = 4'd7;
    @(negedge clk);
    nr_b = 1'b0;
    check("b_cv", cv_b, 1);
    check("b_bits", bits_b, 16'h0080);
    nr_b = 1'b1;
    x_b  = 4'd2;
    @(negedge clk);
    nr_b = 1'b0;
    check("b_hold_frozen", bits_b, 16'h0080);

    // instance c: latency 2 + 48*11 = 530, all 16 codes seen
    start_c = 1'b1;
    @(posedge clk);
    #1 start_c = 1'b0;
    repeat (529) @(posedge clk);
    #1 check("c_cv_529", cv_c, 0);
    @(posedge clk);
    #1 check("c_cv_530", cv_c, 1);
    check("c_bits", bits_c, 16'hFFFF);
    check("c_busy", busy_c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule
